// File: rtl/collect3.sv
`default_nettype none
// ============================================================================
// collect3 : gathers one result pixel per engine, then drains the batch
//            as a raster-ordered valid/ready stream with SOF/EOL flags.
// Revision : 1.0
// ============================================================================
module collect3 #(
   parameter int COLOUR_WIDTH  = 24,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int NUM_ENGINES   = 3
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_ENGINES-1:0]              eng_valid,
   input  logic [NUM_ENGINES*COLOUR_WIDTH-1:0] eng_data,
   output logic [NUM_ENGINES-1:0]              eng_ready,
   output logic [COLOUR_WIDTH-1:0]             out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                out_sof,
   output logic                                out_eol,
   output logic                                fin_flag
);
   localparam int c_XW = $clog2(SCREEN_WIDTH);
   localparam int c_YW = $clog2(SCREEN_HEIGHT);
   localparam int c_IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
   localparam logic [c_XW-1:0] c_X_LAST   = c_XW'(SCREEN_WIDTH - 1);
   localparam logic [c_YW-1:0] c_Y_LAST   = c_YW'(SCREEN_HEIGHT - 1);
   localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(NUM_ENGINES - 1);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_DRAIN   = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                  r_state;
   logic [NUM_ENGINES-1:0]  r_full;
   logic [COLOUR_WIDTH-1:0] r_slot [NUM_ENGINES];
   logic [c_IW-1:0]         r_idx;
   logic [c_XW-1:0]         r_x_cnt;
   logic [c_YW-1:0]         r_y_cnt;

   logic [NUM_ENGINES-1:0]  w_take;
   logic [NUM_ENGINES-1:0]  w_full_nxt;
   logic [COLOUR_WIDTH-1:0] w_slot_nxt [NUM_ENGINES];
   logic                    w_xfer;
   logic [c_XW-1:0]         w_x_nxt;
   logic [c_YW-1:0]         w_y_nxt;
   logic [c_IW-1:0]         w_idx_nxt;

   assign eng_ready  = (r_state == S_COLLECT) ? ~r_full : '0;
   assign w_take     = eng_valid & eng_ready;
   assign w_full_nxt = r_full | w_take;

   // Same-cycle fills are visible here so slot 0 can go straight to the output.
   generate
      for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_slot
         assign w_slot_nxt[gi] = w_take[gi] ? eng_data[gi*COLOUR_WIDTH +: COLOUR_WIDTH]
                                            : r_slot[gi];
      end
   endgenerate

   assign w_xfer    = (r_state == S_DRAIN) && out_valid && out_ready;
   assign w_x_nxt   = (r_x_cnt == c_X_LAST) ? '0 : r_x_cnt + c_XW'(1);
   assign w_y_nxt   = (r_x_cnt != c_X_LAST) ? r_y_cnt :
                      (r_y_cnt == c_Y_LAST) ? '0 : r_y_cnt + c_YW'(1);
   assign w_idx_nxt = r_idx + c_IW'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_COLLECT;
         r_full    <= '0;
         for (int i = 0; i < NUM_ENGINES; i++) r_slot[i] <= '0;
         r_idx     <= '0;
         r_x_cnt   <= '0;
         r_y_cnt   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         fin_flag  <= 1'b0;
      end else begin
         fin_flag <= 1'b0;
         case (r_state)
            S_COLLECT: begin
               r_full <= w_full_nxt;
               for (int i = 0; i < NUM_ENGINES; i++) r_slot[i] <= w_slot_nxt[i];
               if (&w_full_nxt) begin
                  r_state   <= S_DRAIN;
                  r_idx     <= '0;
                  out_valid <= 1'b1;
                  out_data  <= w_slot_nxt[0];
                  out_sof   <= (r_x_cnt == '0) && (r_y_cnt == '0);
                  out_eol   <= (r_x_cnt == c_X_LAST);
               end
            end
            S_DRAIN: begin
               if (w_xfer) begin
                  r_full[r_idx] <= 1'b0;
                  r_x_cnt       <= w_x_nxt;
                  r_y_cnt       <= w_y_nxt;
                  if (r_idx == c_IDX_LAST) begin
                     r_state   <= S_DONE;
                     out_valid <= 1'b0;
                     out_sof   <= 1'b0;
                     out_eol   <= 1'b0;
                     fin_flag  <= 1'b1;
                  end else begin
                     // Flags come from the raster counters, so a batch may straddle lines.
                     r_idx    <= w_idx_nxt;
                     out_data <= r_slot[w_idx_nxt];
                     out_sof  <= (w_x_nxt == '0) && (w_y_nxt == '0);
                     out_eol  <= (w_x_nxt == c_X_LAST);
                  end
               end
            end
            S_DONE: begin
               r_full  <= '0;
               r_state <= S_COLLECT;
            end
            default: r_state <= S_COLLECT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_collect3.sv
`default_nettype none
// ============================================================================
// tb_collect3 : directed stimulus with a pixel-queue scoreboard for collect3.
// Revision    : 1.0
// ============================================================================
module tb_collect3;
   localparam int CW = 24;
   localparam int W  = 640;
   localparam int H  = 4;
   localparam int N  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    eng_valid;
   logic [N*CW-1:0] eng_data;
   logic [N-1:0]    eng_ready;
   logic [CW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_sof;
   logic            out_eol;
   logic            fin_flag;

   collect3 #(.COLOUR_WIDTH(CW), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_ENGINES(N)) dut (
      .clk(clk), .reset(reset), .eng_valid(eng_valid), .eng_data(eng_data),
      .eng_ready(eng_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol), .fin_flag(fin_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] data;
      logic          sof;
      logic          eol;
      logic          last;
   } pix_t;

   pix_t          q[$];
   logic [CW-1:0] m_slot [N];
   logic [N-1:0]  m_have  = '0;
   int            m_pos   = 0;
   logic          fin_due = 1'b0;
   int            checks   = 0;
   int            failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_batch(input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                              input logic [CW-1:0] d2);
      tick();
      eng_valid = 3'b111;
      eng_data  = {d2, d1, d0};
      tick();
      eng_valid = 3'b000;
   endtask

   task automatic wait_fin();
      int n;
      n = 0;
      @(negedge clk);
      while (!fin_flag && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("fin_seen", 32'(fin_flag), 32'd1);
   endtask

   function automatic logic [CW-1:0] pat(input int b, input int k);
      return CW'((b << 4) | k | 32'h00A00000);
   endfunction

   initial begin
      fork
         begin : monitor
            pix_t         e;
            logic [N-1:0] take;
            int           pos;
            forever begin
               @(negedge clk);
               chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
               chk("fin_flag", 32'(fin_flag), 32'(fin_due));
               fin_due = 1'b0;
               if (out_valid && q.size() != 0) begin
                  e = q[0];
                  chk("out_data", 32'(out_data), 32'(e.data));
                  chk("out_sof", 32'(out_sof), 32'(e.sof));
                  chk("out_eol", 32'(out_eol), 32'(e.eol));
                  if (out_ready) begin
                     fin_due = e.last;
                     void'(q.pop_front());
                  end
               end
               if (reset) begin
                  take = eng_valid & eng_ready;
                  for (int k = 0; k < N; k++)
                     if (take[k]) begin
                        m_slot[k] = eng_data[k*CW +: CW];
                        m_have[k] = 1'b1;
                     end
                  if (&m_have) begin
                     for (int k = 0; k < N; k++) begin
                        pos    = m_pos + k;
                        e.data = m_slot[k];
                        e.sof  = (pos % (W*H)) == 0;
                        e.eol  = (pos % W) == W-1;
                        e.last = (k == N-1);
                        q.push_back(e);
                     end
                     m_pos  = m_pos + N;
                     m_have = '0;
                  end
               end else begin
                  q.delete();
                  m_have  = '0;
                  m_pos   = 0;
                  fin_due = 1'b0;
               end
            end
         end
         begin : stimulus
            reset = 1'b0; eng_valid = '0; eng_data = '0; out_ready = 1'b1;
            repeat (3) tick();
            reset = 1'b1;
            @(negedge clk);
            chk("rst_ready", 32'(eng_ready), 32'd7);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_fin", 32'(fin_flag), 32'd0);

            // Simultaneous fill, back-to-back drain.
            tick();
            eng_valid = 3'b111;
            eng_data  = {24'h333333, 24'h222222, 24'h111111};
            @(negedge clk);
            chk("a_ready", 32'(eng_ready), 32'd7);
            tick();
            eng_valid = 3'b000;
            @(negedge clk);
            chk("a_pix0", 32'(out_data), 32'h111111);
            chk("a_sof0", 32'(out_sof), 32'd1);
            tick(); @(negedge clk);
            chk("a_pix1", 32'(out_data), 32'h222222);
            chk("a_sof1", 32'(out_sof), 32'd0);
            tick(); @(negedge clk);
            chk("a_pix2", 32'(out_data), 32'h333333);
            tick(); @(negedge clk);
            chk("a_fin", 32'(fin_flag), 32'd1);
            chk("a_idle", 32'(out_valid), 32'd0);
            tick(); @(negedge clk);
            chk("a_fin_once", 32'(fin_flag), 32'd0);

            // Out-of-order completion: engine 3, then 1, then 2.
            tick();
            eng_valid = 3'b100; eng_data = {24'hC3C3C3, 48'h0};
            tick();
            eng_valid = 3'b000;
            @(negedge clk);
            chk("ooo_ready3", 32'(eng_ready), 32'd3);
            tick();
            tick();
            eng_valid = 3'b001; eng_data = {48'h0, 24'hA1A1A1};
            tick();
            eng_valid = 3'b000;
            @(negedge clk);
            chk("ooo_ready1", 32'(eng_ready), 32'd2);
            chk("ooo_nodrain", 32'(out_valid), 32'd0);
            tick();
            eng_valid = 3'b010; eng_data = {24'h0, 24'hB2B2B2, 24'h0};
            tick();
            eng_valid = 3'b000;
            @(negedge clk);
            chk("ooo_first", 32'(out_data), 32'hA1A1A1);
            wait_fin();

            // Downstream stall on the second pixel.
            start_batch(24'h0D0D01, 24'h0D0D02, 24'h0D0D03);
            @(negedge clk);
            tick();
            out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_data", 32'(out_data), 32'h0D0D02);
               chk("stall_fin", 32'(fin_flag), 32'd0);
               tick();
            end
            out_ready = 1'b1;
            wait_fin();

            // Fill line 0 up to x=639 (9 pixels sent so far).
            for (int b = 0; b < 210; b++) begin
               start_batch(pat(b, 0), pat(b, 1), pat(b, 2));
               wait_fin();
            end
            start_batch(24'hE0E0E0, 24'hE1E1E1, 24'hE2E2E2);
            @(negedge clk);
            chk("eol_x639", 32'(out_eol), 32'd1);
            tick(); @(negedge clk);
            chk("eol_x0_line1", 32'(out_eol), 32'd0);
            chk("sof_line1", 32'(out_sof), 32'd0);
            wait_fin();

            // Advance to the last pixel of the frame (position 2559).
            for (int b = 0; b < 639; b++) begin
               start_batch(pat(b, 4), pat(b, 5), pat(b, 6));
               wait_fin();
            end
            start_batch(24'hF0F0F0, 24'hF1F1F1, 24'hF2F2F2);
            @(negedge clk);
            chk("frame_last_eol", 32'(out_eol), 32'd1);
            chk("frame_last_sof", 32'(out_sof), 32'd0);
            tick(); @(negedge clk);
            chk("frame_wrap_sof", 32'(out_sof), 32'd1);
            chk("frame_wrap_data", 32'(out_data), 32'hF1F1F1);
            wait_fin();

            // Reset with two slots full discards the partial batch.
            tick();
            eng_valid = 3'b011; eng_data = {24'h0, 24'h999999, 24'h888888};
            tick();
            eng_valid = 3'b000;
            @(negedge clk);
            chk("part_ready", 32'(eng_ready), 32'd4);
            tick();
            reset = 1'b0;
            tick();
            tick();
            reset = 1'b1;
            @(negedge clk);
            chk("post_rst_ready", 32'(eng_ready), 32'd7);
            repeat (3) begin
               tick(); @(negedge clk);
               chk("post_rst_valid", 32'(out_valid), 32'd0);
               chk("post_rst_fin", 32'(fin_flag), 32'd0);
            end
            start_batch(24'h123456, 24'h234567, 24'h345678);
            @(negedge clk);
            chk("post_rst_sof", 32'(out_sof), 32'd1);
            chk("post_rst_data", 32'(out_data), 32'h123456);
            wait_fin();

            repeat (2) tick();
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
         begin : watchdog
            #2000000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "time limit");
         end
      join
   end

endmodule
`default_nettype wire

// File: doc/collect3.md
Name: collect3

Overview:
- Return-path counterpart to the three-engine coordinate distributor.
- Accepts one result pixel from each of NUM_ENGINES engines per batch and buffers the batch.
- Emits the buffered pixels as a single raster-ordered stream with valid/ready, start-of-frame and end-of-line flags.
- Pulses fin_flag back to the distributor when a batch has fully drained, so the next coordinate batch is issued.

Parameters:
- COLOUR_WIDTH, 24, width of one engine result pixel (RGB888).
- SCREEN_WIDTH, 640, pixels per line.
- SCREEN_HEIGHT, 480, lines per frame.
- NUM_ENGINES, 3, engines per batch; legal range 1..8. Slot i carries the pixel at raster offset i of the batch.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- eng_valid  input  NUM_ENGINES  bit i: engine i+1 presents a result.
- eng_data  input  NUM_ENGINES*COLOUR_WIDTH  slot i occupies bits [(i+1)*COLOUR_WIDTH-1 : i*COLOUR_WIDTH].
- eng_ready  output  NUM_ENGINES  bit i: slot i empty and block in COLLECT.
- out_data  output  COLOUR_WIDTH  current stream pixel.
- out_valid  output  1  out_data/out_sof/out_eol valid.
- out_ready  input  1  downstream accepts the pixel when out_valid && out_ready.
- out_sof  output  1  current pixel is x=0, y=0.
- out_eol  output  1  current pixel is x=SCREEN_WIDTH-1.
- fin_flag  output  1  one-cycle pulse: batch drained, distributor may advance.

Behaviour:
- Reset (reset==0 at edge):
  - All slot-full bits cleared, slot registers zeroed.
  - State COLLECT, slot index 0, x_cnt=0, y_cnt=0.
  - out_valid=0, out_sof=0, out_eol=0, out_data=0, fin_flag=0.
  - eng_ready is all-ones from the first cycle after reset releases.
  - Reset mid-batch or mid-drain discards the partial batch; no fin_flag is issued for it.
- States: COLLECT -> DRAIN -> DONE -> COLLECT.
- COLLECT:
  - eng_ready[i] = ~full[i].
  - A handshake on slot i (eng_valid[i] && eng_ready[i]) latches that slot's data and sets full[i].
  - Slots fill in any order; simultaneous handshakes are all accepted in the same cycle.
  - A valid held on a full slot is not accepted (ready=0) and is not lost.
  - When all full bits are set (including same-cycle fills), the next state is DRAIN with idx=0.
- DRAIN:
  - eng_ready=0.
  - out_valid=1, out_data=slot[idx], out_sof=(x_cnt==0 && y_cnt==0), out_eol=(x_cnt==SCREEN_WIDTH-1).
  - Outputs are registered and held stable while out_ready=0 (no change while stalled).
  - On transfer: full[idx] cleared, x_cnt increments.
    - At SCREEN_WIDTH-1, x_cnt wraps to 0 and y_cnt increments.
    - At SCREEN_HEIGHT-1, y_cnt wraps to 0.
    - A batch may straddle a line or frame boundary (640 mod 3 = 1); the flags follow the counters, not the slot index.
  - After the transfer of idx=NUM_ENGINES-1, the next state is DONE and out_valid drops.
- DONE: fin_flag=1 for exactly one cycle; next state COLLECT, all slots empty.
- Latency: the first output pixel is valid on the cycle after the last slot fills. fin_flag asserts the cycle after the final transfer. Best-case batch period is NUM_ENGINES+2 cycles.
- Counter widths: x_cnt is $clog2(SCREEN_WIDTH) bits and y_cnt is $clog2(SCREEN_HEIGHT) bits, compared with full-width constants (no truncation wrap).

Test Plan:
- Reset held low 3 cycles, then released -> out_valid=0, fin_flag=0, eng_ready=3'b111.
- All three engines valid in one cycle with 0x111111/0x222222/0x333333, out_ready=1 -> next 3 cycles emit 111111, 222222, 333333. The first carries out_sof=1. fin_flag pulses on the following cycle.
- Engines complete out of order (engine 3, then 1 two cycles later, then 2) -> the output order is still slot1, slot2, slot3. eng_ready[2] is 0 while slot 3 waits. Nothing drains before slot 2 fills.
- out_ready low for 4 cycles mid-drain -> out_data/out_valid/out_eol held constant, fin_flag not asserted until the final pixel transfers.
- Run 213 batches (639 pixels), then one more batch -> its first pixel has out_eol=1 (x=639), its second has x=0 on line 1. Repeat to 102400 batches -> the pixel after the frame's last is x=0, y=0 with out_sof=1.
- Reset asserted with 2 slots full -> after release eng_ready=3'b111, no output and no fin_flag. The next batch's first pixel has out_sof=1.
